apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
Parametrised APB master that turns a valid/ready command interface into APB transfers to NUM_SLAVES slaves. It decodes addresses, supports wait states via per-slave pready, and returns per-slave pslverr. It adds a decode-error response for unmapped addresses and a PREADY timeout. It replaces the fixed two-slave 9-bit/8-bit master inside apb_top.

Parameters:
ADDR_W, 9, command/APB address width
DATA_W, 8, data width
NUM_SLAVES, 2, number of APB slaves (1..16)
SLV_WIN_W, 7, slave window bits; slave index = addr[ADDR_W-1:SLV_WIN_W]
TIMEOUT, 16, max ACCESS cycles before abort; 0 disables timeout

Ports:
pclk  in  1  clock, all logic on rising edge
presetn  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  error flag, valid with rsp_valid
psel  out  NUM_SLAVES  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  NUM_SLAVES*DATA_W  slave i read data at [i*DATA_W +: DATA_W]
pready  in  NUM_SLAVES  per-slave ready
pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Clocking/reset: one clock, pclk. Reset is synchronous and active-low on presetn, sampled at the pclk rising edge.
- Reset values: state IDLE. psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and the timeout counter are all 0.
- Reset mid-transfer drops the transfer. No rsp_valid is produced for it. Outputs are at reset values in the cycle after the reset edge.
- FSM states: IDLE, SETUP, ACCESS. cmd_ready = (state==IDLE). It is combinational from state only.
- Accept: at the edge where cmd_valid && cmd_ready, the bridge latches cmd_write, cmd_addr and cmd_wdata, and computes idx = cmd_addr[ADDR_W-1:SLV_WIN_W].
- Decode error (idx >= NUM_SLAVES):
  - The FSM stays in IDLE and no psel is asserted.
  - In the next cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Valid decode: IDLE->SETUP.
  - SETUP (exactly 1 cycle): psel[idx]=1, penable=0. paddr, pwrite and pwdata are driven from the latched values; pwdata=0 for reads. Then SETUP->ACCESS.
  - ACCESS: psel[idx]=1, penable=1. paddr, pwrite, pwdata, psel are held stable for the whole ACCESS phase.
  - Completion: an ACCESS cycle with pready[idx]=1.
  - At the completion edge: state->IDLE, psel/penable->0. rsp_rdata = read ? prdata[idx] : 0. rsp_err = pslverr[idx].
  - On error, rsp_rdata is forced to 0.
  - rsp_valid=1 for the cycle after completion.
- Timeout:
  - The counter clears on entry to ACCESS and increments in each ACCESS cycle with pready[idx]=0.
  - If TIMEOUT!=0 and the TIMEOUT-th ACCESS cycle still has pready[idx]=0, the transfer aborts at that edge. ACCESS therefore lasts exactly TIMEOUT cycles.
  - Abort: psel/penable->0, state->IDLE, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Latency from the accept edge to the rsp_valid cycle:
  - Minimum: 3 cycles (zero wait states).
  - With W wait states: 3+W cycles.
  - Decode error: 1 cycle.
- Back-to-back: a new command may be accepted in the same cycle rsp_valid is high, since the FSM is in IDLE. Maximum throughput is 1 transfer per 3 cycles.
- Unselected slaves: their pready, pslverr and prdata are ignored. Inputs are sampled only in ACCESS.
- pwdata, paddr and pwrite keep their last values in IDLE. psel and penable are 0 in IDLE.
- Counter width is $clog2(TIMEOUT+1), with a minimum of 1.

Test Plan:
1. Write 0x005/0xAA, slave0 pready=1 -> psel=01 for 2 cycles (SETUP, ACCESS), pwdata=0xAA, rsp_valid at accept+3, rsp_err=0.
2. Read 0x085, slave1 prdata=0x5A, pready low for 3 ACCESS cycles -> psel=10 held, rsp_rdata=0x5A, rsp_err=0 at accept+6.
3. Write 0x1FF (idx=3) -> psel stays 00, rsp_valid at accept+1 with rsp_err=1, rsp_rdata=0.
4. Read 0x010, slave0 pslverr=1 with pready=1, prdata=0x77 -> rsp_err=1, rsp_rdata=0x00.
5. TIMEOUT=16, read 0x020 with pready held 0 -> penable high exactly 16 cycles, then psel=00, rsp_err=1. A follow-up write 0x030/0x33 completes normally.
6. presetn low for 1 cycle during ACCESS of write 0x030 -> psel=00, penable=0 next cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Parametrised APB master. Accepts valid/ready commands, decodes the
//            slave from the upper address bits, runs SETUP/ACCESS phases with
//            wait-state support, and returns a one-cycle response pulse.
//            Unmapped addresses get an immediate decode-error response, and a
//            slave that holds pready low for too long is aborted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   pclk, presetn          clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_write/addr/wdata   command payload, latched at accept
//   rsp_valid/rdata/err    one-cycle response pulse and its payload
//   psel/penable/pwrite    APB control (psel is one-hot per slave)
//   paddr/pwdata           APB address and write data
//   prdata/pready/pslverr  packed per-slave APB returns
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int SLV_WIN_W  = 7,
  parameter int TIMEOUT    = 16
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int IDX_W = ADDR_W - SLV_WIN_W;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last permitted ACCESS cycle.
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [IDX_W-1:0]      cmd_idx;
  logic                  decode_ok;
  logic [NUM_SLAVES-1:0] cmd_hit;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  timeout_hit;

  assign cmd_idx   = cmd_addr[ADDR_W-1:SLV_WIN_W];
  assign decode_ok = (32'(cmd_idx) < 32'(NUM_SLAVES));

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
    assign cmd_hit[g] = (32'(cmd_idx) == 32'(g));
  end

  // The registered one-hot psel doubles as the return-path selector, so
  // unselected slaves can never influence the response.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        sel_ready = sel_ready | pready[i];
        sel_err   = sel_err | pslverr[i];
        sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TO_LAST);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (decode_ok) begin
            state_d  = SETUP;
            psel_d   = cmd_hit;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
          end else begin
            // Unmapped: answer next cycle without touching the APB bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            state_d     = IDLE;
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
